// File: rtl/class_fifo_bank_pkg.sv
// Shared definitions for the per-traffic-class FIFO bank and the class arbiter
// that feeds it. Class k is carried on one-hot bit k of push/pop vectors.
package class_fifo_bank_pkg;

   localparam int NUM_CLASSES = 4;

   // Class encoding shared with the arbiter.
   typedef enum logic [1:0] {
      CLASS_0 = 2'd0,
      CLASS_1 = 2'd1,
      CLASS_2 = 2'd2,
      CLASS_3 = 2'd3
   } class_e;

   localparam logic [NUM_CLASSES-1:0] CLASS_0_OH = 4'b0001;
   localparam logic [NUM_CLASSES-1:0] CLASS_1_OH = 4'b0010;
   localparam logic [NUM_CLASSES-1:0] CLASS_2_OH = 4'b0100;
   localparam logic [NUM_CLASSES-1:0] CLASS_3_OH = 4'b1000;

   // Map a class index onto its one-hot push/pop bit.
   function automatic logic [NUM_CLASSES-1:0] class_to_onehot(input class_e c);
      return NUM_CLASSES'(1) << c;
   endfunction

endpackage

// File: rtl/class_fifo.sv
// Single synchronous FIFO for one traffic class: write/read pointers, an
// occupancy count from which every flag is decoded, sticky error flags and a
// registered read port with one cycle of latency. No fall-through path.
module class_fifo
   import class_fifo_bank_pkg::*;
#(
   parameter int DATA_W    = 10,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = 6,
   parameter int AE_THRESH = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              push,
   input  logic              pop,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow_err,
   output logic              underflow_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              valid_q, valid_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              push_ok, pop_ok;

   // Flags come only from the registered count, never from pointer compares.
   assign empty        = (count_q == '0);
   assign full         = (count_q == CNT_W'(DEPTH));
   assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
   assign almost_empty = (count_q <= CNT_W'(AE_THRESH));

   // A full FIFO still takes a push when a pop frees the slot in the same cycle.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;

   // Next-state for pointers, count, read port and sticky errors.
   always_comb begin
      // NOTE: every _d gets a default from its _q first, so no path leaves a latch.
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      data_out_d = data_out_q;
      valid_d    = pop_ok;
      ovf_d      = ovf_q | (push & ~push_ok);
      unf_d      = unf_q | (pop & ~pop_ok);
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok) begin
         rptr_d     = rptr_q + 1'b1;
         data_out_d = mem_q[rptr_q];
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage write: the read above sees the old entry, so full push+pop is safe.
   always_comb begin
      mem_d = mem_q;
      if (push_ok) mem_d[wptr_q] = data_in;
   end

   // Control state with synchronous reset taking priority over traffic.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         data_out_q <= '0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   // Storage array update.
   always_ff @(posedge clk) begin
      // NOTE: the array is not reset; a zero count makes stale entries unreachable.
      mem_q <= mem_d;
   end

   assign data_out      = data_out_q;
   assign valid_out     = valid_q;
   assign overflow_err  = ovf_q;
   assign underflow_err = unf_q;

endmodule

// File: rtl/class_fifo_bank.sv
// Bank of independent per-class FIFOs downstream of the class arbiter. The
// shared data_in word is captured by every FIFO whose push bit is set; each
// class is drained on its own pop bit and reports its own flags.
module class_fifo_bank
   import class_fifo_bank_pkg::*;
#(
   parameter int DATA_W    = 10,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = 6,
   parameter int AE_THRESH = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_W-1:0]             data_in,
   input  logic [NUM_CLASSES-1:0]        push,
   input  logic [NUM_CLASSES-1:0]        pop,
   output logic [NUM_CLASSES*DATA_W-1:0] data_out,
   output logic [NUM_CLASSES-1:0]        valid_out,
   output logic [NUM_CLASSES-1:0]        empty,
   output logic [NUM_CLASSES-1:0]        full,
   output logic [NUM_CLASSES-1:0]        almost_full,
   output logic [NUM_CLASSES-1:0]        almost_empty,
   output logic [NUM_CLASSES-1:0]        overflow_err,
   output logic [NUM_CLASSES-1:0]        underflow_err
);

   for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_class
      class_fifo #(
         .DATA_W    (DATA_W),
         .DEPTH     (DEPTH),
         .AF_THRESH (AF_THRESH),
         .AE_THRESH (AE_THRESH)
      ) u_fifo (
         .clk           (clk),
         .reset         (reset),
         .data_in       (data_in),
         .push          (push[k]),
         .pop           (pop[k]),
         .data_out      (data_out[k*DATA_W +: DATA_W]),
         .valid_out     (valid_out[k]),
         .empty         (empty[k]),
         .full          (full[k]),
         .almost_full   (almost_full[k]),
         .almost_empty  (almost_empty[k]),
         .overflow_err  (overflow_err[k]),
         .underflow_err (underflow_err[k])
      );
   end

endmodule

// File: tb/tb_class_fifo_bank.sv
// Self-checking bench for class_fifo_bank: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_class_fifo_bank;
   import class_fifo_bank_pkg::*;

   localparam int DATA_W = 10;
   localparam int DEPTH  = 8;
   localparam int AF     = 6;
   localparam int AE     = 1;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [DATA_W-1:0]      data_in;
   logic [3:0]             push, pop;
   logic [4*DATA_W-1:0]    data_out;
   logic [3:0]             valid_out, empty, full, almost_full, almost_empty;
   logic [3:0]             overflow_err, underflow_err;

   always #5 clk = ~clk;

   class_fifo_bank #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .data_in       (data_in),
      .push          (push),
      .pop           (pop),
      .data_out      (data_out),
      .valid_out     (valid_out),
      .empty         (empty),
      .full          (full),
      .almost_full   (almost_full),
      .almost_empty  (almost_empty),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: one queue per class plus the visible read-port state.
   logic [DATA_W-1:0] mq [4][$];
   logic [DATA_W-1:0] m_dout [4];
   logic [3:0]        m_valid, m_ovf, m_unf;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic rst, input logic [3:0] ps, input logic [3:0] pp,
                             input logic [DATA_W-1:0] d);
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            m_dout[k] = '0;
         end
         m_valid = '0;
         m_ovf   = '0;
         m_unf   = '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            int  n       = mq[k].size();
            bit  pop_ok  = pp[k] && (n > 0);
            bit  push_ok = ps[k] && ((n < DEPTH) || pp[k]);
            m_valid[k] = pop_ok;
            if (pop_ok) m_dout[k] = mq[k].pop_front();
            if (push_ok) mq[k].push_back(d);
            if (ps[k] && !push_ok) m_ovf[k] = 1'b1;
            if (pp[k] && !pop_ok) m_unf[k] = 1'b1;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [4*DATA_W-1:0] ed;
      logic [3:0] e_empty, e_full, e_af, e_ae;
      for (int k = 0; k < 4; k++) begin
         int n = mq[k].size();
         ed[k*DATA_W +: DATA_W] = m_dout[k];
         e_empty[k] = (n == 0);
         e_full[k]  = (n == DEPTH);
         e_af[k]    = (n >= AF);
         e_ae[k]    = (n <= AE);
      end
      check({tag, ".data_out"},      64'(data_out),      64'(ed));
      check({tag, ".valid_out"},     64'(valid_out),     64'(m_valid));
      check({tag, ".empty"},         64'(empty),         64'(e_empty));
      check({tag, ".full"},          64'(full),          64'(e_full));
      check({tag, ".almost_full"},   64'(almost_full),   64'(e_af));
      check({tag, ".almost_empty"},  64'(almost_empty),  64'(e_ae));
      check({tag, ".overflow_err"},  64'(overflow_err),  64'(m_ovf));
      check({tag, ".underflow_err"}, 64'(underflow_err), 64'(m_unf));
   endtask

   // One clock of traffic: drive, clock, advance model, compare.
   task automatic cycle(input logic [3:0] ps, input logic [3:0] pp,
                        input logic [DATA_W-1:0] d, input string tag);
      reset   = 1'b0;
      push    = ps;
      pop     = pp;
      data_in = d;
      @(posedge clk);
      model_step(1'b0, ps, pp, d);
      #1;
      check_outputs(tag);
      push = '0;
      pop  = '0;
   endtask

   // One clock with reset held, optionally alongside push/pop traffic.
   task automatic reset_cycle(input logic [3:0] ps, input logic [3:0] pp, input string tag);
      reset   = 1'b1;
      push    = ps;
      pop     = pp;
      data_in = 10'h2C3;
      @(posedge clk);
      model_step(1'b1, ps, pp, 10'h2C3);
      #1;
      check_outputs(tag);
      reset = 1'b0;
      push  = '0;
      pop   = '0;
   endtask

   initial begin
      reset   = 1'b1;
      push    = '0;
      pop     = '0;
      data_in = '0;
      for (int k = 0; k < 4; k++) m_dout[k] = '0;
      m_valid = '0;
      m_ovf   = '0;
      m_unf   = '0;

      // Reset values.
      reset_cycle(4'h0, 4'h0, "rst0");
      reset_cycle(4'h0, 4'h0, "rst1");
      check("rst.empty_lit",        64'(empty),        64'h0F);
      check("rst.almost_empty_lit", 64'(almost_empty), 64'h0F);

      // Per-class ordering on class 2.
      cycle(CLASS_2_OH, 4'h0, 10'h011, "ord.push0");
      cycle(CLASS_2_OH, 4'h0, 10'h022, "ord.push1");
      cycle(CLASS_2_OH, 4'h0, 10'h033, "ord.push2");
      cycle(4'h0, CLASS_2_OH, 10'h000, "ord.pop0");
      check("ord.first", 64'(data_out[29:20]), 64'h011);
      cycle(4'h0, CLASS_2_OH, 10'h000, "ord.pop1");
      check("ord.second", 64'(data_out[29:20]), 64'h022);
      cycle(4'h0, CLASS_2_OH, 10'h000, "ord.pop2");
      check("ord.third", 64'(data_out[29:20]), 64'h033);
      check("ord.empty2", 64'(empty[2]), 64'h1);
      check("ord.valid2", 64'(valid_out[2]), 64'h1);

      // Threshold, full and overflow on class 0.
      for (int i = 0; i < 6; i++) cycle(CLASS_0_OH, 4'h0, DATA_W'(10'h100 + i), "thr.push");
      check("thr.af0", 64'(almost_full[0]), 64'h1);
      check("thr.full0_early", 64'(full[0]), 64'h0);
      cycle(CLASS_0_OH, 4'h0, 10'h106, "thr.push7");
      cycle(CLASS_0_OH, 4'h0, 10'h107, "thr.push8");
      check("thr.full0", 64'(full[0]), 64'h1);
      cycle(CLASS_0_OH, 4'h0, 10'h3FF, "thr.push9");
      check("thr.ovf0", 64'(overflow_err[0]), 64'h1);
      for (int i = 0; i < 8; i++) cycle(4'h0, CLASS_0_OH, 10'h000, "thr.drain");
      check("thr.last0", 64'(data_out[9:0]), 64'h107);

      // Full with simultaneous push and pop on class 1.
      for (int i = 0; i < 8; i++) cycle(CLASS_1_OH, 4'h0, DATA_W'(10'h200 + i), "fpp.fill");
      cycle(CLASS_1_OH, CLASS_1_OH, 10'h2AA, "fpp.both");
      check("fpp.oldest", 64'(data_out[19:10]), 64'h200);
      check("fpp.still_full", 64'(full[1]), 64'h1);
      for (int i = 0; i < 8; i++) cycle(4'h0, CLASS_1_OH, 10'h000, "fpp.drain");
      check("fpp.newest_last", 64'(data_out[19:10]), 64'h2AA);

      // Empty with simultaneous push and pop on class 3.
      cycle(CLASS_3_OH, CLASS_3_OH, 10'h155, "epp.both");
      check("epp.valid3", 64'(valid_out[3]), 64'h0);
      check("epp.unf3", 64'(underflow_err[3]), 64'h1);
      check("epp.not_empty3", 64'(empty[3]), 64'h0);
      cycle(4'h0, CLASS_3_OH, 10'h000, "epp.pop");
      check("epp.data3", 64'(data_out[39:30]), 64'h155);

      // Reset mid-traffic with every class holding three words.
      reset_cycle(4'h0, 4'h0, "mid.clr");
      for (int i = 0; i < 3; i++) cycle(4'hF, 4'h0, DATA_W'(10'h0A0 + i), "mid.fill");
      reset_cycle(4'hF, 4'hF, "mid.rst");
      check("mid.empty_lit", 64'(empty), 64'h0F);
      cycle(4'h0, 4'hF, 10'h000, "mid.pop_after");
      check("mid.no_valid", 64'(valid_out), 64'h0);

      // Random traffic against the model, with occasional resets.
      reset_cycle(4'h0, 4'h0, "rnd.rst");
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 63) == 0) begin
            reset_cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rnd.rst");
         end else begin
            cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  DATA_W'($urandom), "rnd");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/class_fifo_bank.md
# class_fifo_bank

Bank of four independent synchronous FIFOs, one per traffic class, sitting directly downstream of the class arbiter in the PCIe datapath. The arbiter's one-hot `push[3:0]` selects which class FIFO captures the shared `data_in` word. The bank reports per-class occupancy flags, and `almost_full[3:0]` is fed back to the arbiter for flow control. The downstream consumer drains each class FIFO independently with `pop[3:0]`.

## Interface
- `DATA_W`, 10: word width.
- `DEPTH`, 8: entries per class FIFO; power of two, ≥4.
- `AF_THRESH`, 6: `almost_full[k]` asserts when `count[k] >= AF_THRESH`; must satisfy `DEPTH - AF_THRESH >= 2`.
- `AE_THRESH`, 1: `almost_empty[k]` asserts when `count[k] <= AE_THRESH`.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `data_in` in DATA_W: shared write data from the upstream FIFO.
- `push` in 4: per-class write enable; bit k writes FIFO k.
- `pop` in 4: per-class read request from the downstream consumer.
- `data_out` out 4*DATA_W: class k word on bits [k*DATA_W +: DATA_W]; registered.
- `valid_out` out 4: bit k pulses one cycle when `data_out` slice k holds a newly popped word.
- `empty` out 4: count == 0.
- `full` out 4: count == DEPTH.
- `almost_full` out 4: see `AF_THRESH`.
- `almost_empty` out 4: see `AE_THRESH`.
- `overflow_err` out 4: sticky; set on a push that is dropped.
- `underflow_err` out 4: sticky; set on a pop that is ignored.

## Operation
- Each class FIFO has a write pointer, a read pointer (log2(DEPTH) bits, wrapping at DEPTH) and a count (log2(DEPTH)+1 bits).
- All flags are combinational decodes of the registered count. They are never derived from the pointers.
- **Push accepted:** `push[k]` is accepted when `!full[k]`, or when `full[k] && pop[k]` in the same cycle. An accepted push writes `data_in` at wptr and increments wptr.
- **Pop accepted:** `pop[k]` is accepted when `!empty[k]`. An accepted pop loads the entry at rptr into the `data_out` slice, sets `valid_out[k]`, and increments rptr.
- **Count update:** +1 for push-only, −1 for pop-only, unchanged when both are accepted or neither is.
- **Push and pop together on an empty FIFO:** the push is accepted and the pop is ignored; `underflow_err[k]` is set. There is no fall-through.
- **Push while full with no pop:** data is dropped, pointers and count are unchanged, `overflow_err[k]` is set.
- **Pop while empty:** ignored; `underflow_err[k]` is set; `valid_out[k]` stays 0.
- Multiple `push` bits set in one cycle are legal: each selected FIFO captures the same `data_in`.
- When no pop is accepted, `data_out` slice k holds its last value.
- Error flags clear only on reset.

## Timing
- **Reset values:** all pointers and counts 0; `empty` = 4'b1111; `almost_empty` = 4'b1111; `full`, `almost_full` = 0; `data_out` = 0; `valid_out` = 0; error flags = 0.
- Reset has priority over push and pop in the same cycle. A reset asserted mid-traffic discards all contents.
- **Write to flags:** a push at edge N is visible in count, `empty` and `almost_full` after edge N.
- **Read latency:** a pop sampled at edge N produces `data_out` and `valid_out` after edge N, i.e. one cycle of latency.
- **Write-to-read:** a word pushed at edge N can be popped at edge N+1 at the earliest, appearing on `data_out` after N+1.
- **Flow-control headroom:** the arbiter registers its push one cycle after sampling `almost_full`. `DEPTH - AF_THRESH >= 2` therefore guarantees no overflow under legal arbiter behaviour.

## Structure
- **Shared package:** `NUM_CLASSES` = 4, and the class encoding constants (class 0..3 ↔ one-hot bit 0..3) shared with the arbiter.
- **Sub-module:** `class_fifo` implements a single FIFO with pointers, count, flags, errors and the registered read port. `class_fifo_bank` instantiates it four times and packs the output vectors.

## Test plan
- **Reset:** after reset, `empty` = 4'hF, `almost_empty` = 4'hF, all other outputs 0.
- **Per-class ordering:** push 0x011, 0x022, 0x033 with `push` = 4'b0100, then pop class 2 three times. `data_out[29:20]` = 0x011, 0x022, 0x033 on consecutive cycles with `valid_out[2]` high; `empty[2]` asserts after the third pop. Other classes remain untouched.
- **Threshold and full:** 6 pushes to class 0 assert `almost_full[0]`. The 8th push asserts `full[0]`. A 9th push without pop sets `overflow_err[0]`; count stays 8 and the dropped word never appears on reads.
- **Full with simultaneous push and pop:** with class 1 full, assert `push[1]` and `pop[1]` together. Count stays 8, the oldest word is output, and the new word is read last after 8 pops. Pointers wrap correctly.
- **Empty with simultaneous push and pop:** on empty class 3, assert `push[3]` and `pop[3]` together. Count becomes 1, `valid_out[3]` = 0, `underflow_err[3]` = 1.
- **Reset mid-traffic:** assert reset while classes 0–3 each hold 3 words and push/pop are active. All outputs return to reset values, and the next pop of any class is ignored.
